// File: rtl/fb_pkg.sv
// Framebuffer geometry, pixel width and host command encodings shared by the
// pixel loader and the VGA scan-out stage.
package fb_pkg;

  localparam int FB_W     = 200;
  localparam int FB_H     = 150;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int FB_AW    = 15;
  localparam int PIX_W    = 3;

  typedef enum logic [1:0] {
    MODE_WRITE = 2'b00,
    MODE_HOME  = 2'b01,
    MODE_FILL  = 2'b10,
    MODE_SKIP  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Cursor step: the last entry of the framebuffer wraps back to zero.
  function automatic logic [FB_AW-1:0] addr_inc(input logic [FB_AW-1:0] addr,
                                                input int depth);
    if (int'(addr) == depth - 1) return '0;
    return addr + FB_AW'(1);
  endfunction

endpackage

// File: rtl/pixel_loader_if.sv
// Host command port plus framebuffer write port of the pixel loader.
interface pixel_loader_if;
  import fb_pkg::*;

  logic             strobe_n;
  logic [1:0]       mode;
  logic [PIX_W-1:0] pix_data;
  logic             fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [PIX_W-1:0] fb_data;
  logic             busy;
  logic             overrun;

  modport slave (
    input  strobe_n, mode, pix_data,
    output fb_we, fb_addr, fb_data, busy, overrun
  );

  modport master (
    output strobe_n, mode, pix_data,
    input  fb_we, fb_addr, fb_data, busy, overrun
  );

endinterface

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for asynchronous inputs, with a per-instance reset
// value so an idle-high strobe comes out of reset inactive.
module sync_ff #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/pixel_loader.sv
// Turns asynchronous host strobes into framebuffer writes: single pixel writes
// at a wrapping cursor, cursor moves, and a full-screen colour fill.
//
// state   | meaning
// IDLE    | waiting for host commands; WRITE/SKIP/HOME/FILL act on the cursor
// FILL    | one write per cycle over the whole framebuffer; strobes are dropped
module pixel_loader #(
  parameter int FB_DEPTH    = fb_pkg::FB_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input logic           CLK,
  input logic           RST_N,
  pixel_loader_if.slave bus
);
  import fb_pkg::*;

  localparam int               SW        = $clog2(SYNC_STAGES + 1);
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_DEPTH - 1);

  logic             strobe_s;
  logic [1:0]       mode_s;
  logic [PIX_W-1:0] data_s;

  sync_ff #(.WIDTH(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_strobe (
    .clk(CLK), .rst_n(RST_N), .d(bus.strobe_n), .q(strobe_s)
  );

  sync_ff #(.WIDTH(2), .DEPTH(SYNC_STAGES), .RST_VAL(2'b00)) u_sync_mode (
    .clk(CLK), .rst_n(RST_N), .d(bus.mode), .q(mode_s)
  );

  sync_ff #(.WIDTH(PIX_W), .DEPTH(SYNC_STAGES), .RST_VAL({PIX_W{1'b0}})) u_sync_data (
    .clk(CLK), .rst_n(RST_N), .d(bus.pix_data), .q(data_s)
  );

  logic             strobe_prev;
  logic [SW-1:0]    settle;
  logic             fall;
  logic             ev;
  mode_e            cmd;
  logic [PIX_W-1:0] cmd_data;

  assign fall = strobe_prev & ~strobe_s;

  // While the synchroniser refills after reset, the previous-strobe flop is
  // held low so a strobe already low at release cannot look like a fall.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      strobe_prev <= 1'b1;
      settle      <= SW'(SYNC_STAGES);
      ev          <= 1'b0;
      cmd         <= MODE_WRITE;
      cmd_data    <= '0;
    end else begin
      if (settle != '0) begin
        settle      <= settle - SW'(1);
        strobe_prev <= 1'b0;
      end else begin
        strobe_prev <= strobe_s;
      end
      ev <= fall;
      if (fall) begin
        cmd      <= mode_e'(mode_s);
        cmd_data <= data_s;
      end
    end
  end

  state_e           state, state_n;
  logic [FB_AW-1:0] cursor, cursor_n;
  logic [FB_AW-1:0] fill_cnt, fill_cnt_n;
  logic [PIX_W-1:0] fill_colour, fill_colour_n;
  logic             we_q, we_n;
  logic [FB_AW-1:0] addr_q, addr_n;
  logic [PIX_W-1:0] data_q, data_n;
  logic             overrun_q, overrun_n;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      cursor      <= '0;
      fill_cnt    <= '0;
      fill_colour <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_n;
      cursor      <= cursor_n;
      fill_cnt    <= fill_cnt_n;
      fill_colour <= fill_colour_n;
      we_q        <= we_n;
      addr_q      <= addr_n;
      data_q      <= data_n;
      overrun_q   <= overrun_n;
    end
  end

  always_comb begin
    state_n       = state;
    cursor_n      = cursor;
    fill_cnt_n    = fill_cnt;
    fill_colour_n = fill_colour;
    we_n          = 1'b0;
    addr_n        = addr_q;
    data_n        = data_q;
    overrun_n     = overrun_q;
    case (state)
      ST_IDLE: begin
        if (ev) begin
          case (cmd)
            MODE_WRITE: begin
              we_n     = 1'b1;
              addr_n   = cursor;
              data_n   = cmd_data;
              cursor_n = addr_inc(cursor, FB_DEPTH);
            end
            MODE_SKIP: cursor_n = addr_inc(cursor, FB_DEPTH);
            MODE_HOME: cursor_n = '0;
            MODE_FILL: begin
              state_n       = ST_FILL;
              fill_colour_n = cmd_data;
              we_n          = 1'b1;
              addr_n        = '0;
              data_n        = cmd_data;
              fill_cnt_n    = LAST_ADDR;
            end
            default: ;
          endcase
        end
      end
      ST_FILL: begin
        if (ev) overrun_n = 1'b1;
        // fill_cnt holds the writes still owed after the one now on the port
        if (fill_cnt != '0) begin
          we_n       = 1'b1;
          addr_n     = addr_q + FB_AW'(1);
          data_n     = fill_colour;
          fill_cnt_n = fill_cnt - FB_AW'(1);
        end else begin
          state_n  = ST_IDLE;
          cursor_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.fb_we   = we_q;
  assign bus.fb_addr = addr_q;
  assign bus.fb_data = data_q;
  assign bus.busy    = (state == ST_FILL);
  assign bus.overrun = overrun_q;

endmodule
